// File: rtl/duty_command_parser.sv
// duty_command_parser
//   Decodes ASCII line commands of the form "D<ch><decimal value><CR|LF>"
//   arriving from a UART receiver. Each command writes one registered duty
//   value (clamped to MAX_DUTY) for the PWM channel bank. Every line gets one
//   outcome: a cmd_ok pulse on commit or a cmd_err pulse on rejection. An
//   inter-byte timeout abandons lines that stall part-way through.
//
// Ports
//   clk         system clock
//   reset       asynchronous, active-high reset
//   uart_data   received byte, valid when data_ready=1
//   data_ready  one byte is consumed on every cycle this is high
//   duty_flat   channel k at bits [k*DUTY_W +: DUTY_W]
//   cmd_ok      one-cycle pulse when a command is committed
//   cmd_err     one-cycle pulse when a line is rejected or times out
//   busy        high whenever the parser is in the middle of a line
module duty_command_parser #(
  parameter int NUM_CH      = 4,
  parameter int DUTY_W      = 8,
  parameter int MAX_DUTY    = 100,
  parameter int MAX_DIGITS  = 3,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               uart_data,
  input  logic                     data_ready,
  output logic [NUM_CH*DUTY_W-1:0] duty_flat,
  output logic                     cmd_ok,
  output logic                     cmd_err,
  output logic                     busy
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CHAN    = 2'd1;
  localparam logic [1:0] VAL     = 2'd2;
  localparam logic [1:0] DISCARD = 2'd3;

  // Four bits per decimal digit always holds 10^MAX_DIGITS - 1.
  localparam int ACC_W = 4 * MAX_DIGITS;
  localparam int CNT_W = 3;

  logic [1:0]        state_reg, state_next;
  logic [ACC_W-1:0]  acc_reg, acc_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic [3:0]        ch_reg, ch_next;
  logic              ok_next, err_next;
  logic              wr_en;
  logic [DUTY_W-1:0] wr_value;
  logic              timeout_hit;

  // Byte classification
  logic       is_term, is_digit, is_cmd, chan_ok, count_room;
  logic [3:0] digit;
  logic [31:0] acc_wide;

  assign is_term    = (uart_data == 8'h0D) || (uart_data == 8'h0A);
  assign is_digit   = (uart_data >= 8'h30) && (uart_data <= 8'h39);
  assign is_cmd     = (uart_data == 8'h44) || (uart_data == 8'h64);
  // ASCII digits 0x30..0x39 carry their value in the low nibble.
  assign digit      = uart_data[3:0];
  assign chan_ok    = is_digit && (int'(digit) < NUM_CH);
  assign count_room = int'(count_reg) < MAX_DIGITS;

  // Clamp is evaluated on the full accumulator, before any truncation.
  assign acc_wide = 32'(acc_reg);
  assign wr_value = (acc_wide > 32'(MAX_DUTY)) ? DUTY_W'(MAX_DUTY) : DUTY_W'(acc_reg);

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    count_next = count_reg;
    ch_next    = ch_reg;
    ok_next    = 1'b0;
    err_next   = 1'b0;
    wr_en      = 1'b0;
    if (data_ready) begin
      // A byte always takes priority over a timeout on the same cycle.
      case (state_reg)
        IDLE: begin
          if (is_cmd) begin
            state_next = CHAN;
          end else if (!is_term) begin
            state_next = DISCARD;
            err_next   = 1'b1;
          end
        end
        CHAN: begin
          if (chan_ok) begin
            ch_next    = digit;
            acc_next   = '0;
            count_next = '0;
            state_next = VAL;
          end else begin
            err_next   = 1'b1;
            state_next = is_term ? IDLE : DISCARD;
          end
        end
        VAL: begin
          if (is_digit) begin
            if (count_room) begin
              acc_next   = acc_reg * ACC_W'(10) + ACC_W'(digit);
              count_next = count_reg + 1'b1;
            end else begin
              err_next   = 1'b1;
              state_next = DISCARD;
            end
          end else if (is_term) begin
            state_next = IDLE;
            if (count_reg == '0) begin
              err_next = 1'b1;
            end else begin
              ok_next = 1'b1;
              wr_en   = 1'b1;
            end
          end else begin
            err_next   = 1'b1;
            state_next = DISCARD;
          end
        end
        DISCARD: begin
          if (is_term) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end else if (timeout_hit) begin
      state_next = IDLE;
      // A line already being discarded has had its error reported.
      err_next   = (state_reg == CHAN) || (state_reg == VAL);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      count_reg <= '0;
      ch_reg    <= '0;
      cmd_ok    <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      count_reg <= count_next;
      ch_reg    <= ch_next;
      cmd_ok    <= ok_next;
      cmd_err   <= err_next;
    end
  end

  assign busy = (state_reg != IDLE);

  // One register per channel; only the addressed channel is ever written.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [DUTY_W-1:0] duty_reg;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          duty_reg <= '0;
        end else if (wr_en && (ch_reg == 4'(gi))) begin
          duty_reg <= wr_value;
        end
      end
      assign duty_flat[gi*DUTY_W +: DUTY_W] = duty_reg;
    end
  endgenerate

  // Inter-byte timer: counts idle cycles mid-line. It fires on the cycle
  // that would be the TIMEOUT_CYC-th consecutive idle cycle.
  generate
    if (TIMEOUT_CYC > 0) begin : g_timer
      localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
      logic [TMR_W-1:0] timer_reg;

      assign timeout_hit = !data_ready && (state_reg != IDLE) &&
                           (timer_reg == TMR_W'(TIMEOUT_CYC - 1));

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          timer_reg <= '0;
        end else if (data_ready || (state_reg == IDLE) || timeout_hit) begin
          timer_reg <= '0;
        end else begin
          timer_reg <= timer_reg + 1'b1;
        end
      end
    end else begin : g_no_timer
      assign timeout_hit = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_duty_command_parser.sv
// Directed testbench for duty_command_parser with a pulse scoreboard.
// Stimulus pushes the expected pulse kind and the duty_flat image expected
// when that pulse is visible; a monitor pops one entry per observed pulse.
module tb_duty_command_parser;

  logic        clk;
  logic        reset;
  logic [7:0]  uart_data;
  logic        data_ready;
  logic [31:0] duty_flat;
  logic        cmd_ok;
  logic        cmd_err;
  logic        busy;

  duty_command_parser #(
    .NUM_CH      (4),
    .DUTY_W      (8),
    .MAX_DUTY    (100),
    .MAX_DIGITS  (3),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .uart_data  (uart_data),
    .data_ready (data_ready),
    .duty_flat  (duty_flat),
    .cmd_ok     (cmd_ok),
    .cmd_err    (cmd_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_ok;
    logic [31:0] duty;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_pass   = 0;
  int ok_seen  = 0;
  int err_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic expect_pulse(input bit ok, input logic [31:0] d);
    exp_t e;
    e.is_ok = ok;
    e.duty  = d;
    sb.push_back(e);
  endtask

  // Called at a falling edge; the byte is sampled on the next rising edge.
  task automatic send_byte(input logic [7:0] b);
    uart_data  = b;
    data_ready = 1'b1;
    @(negedge clk);
    data_ready = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: one scoreboard entry per cycle with a pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && (cmd_ok || cmd_err)) begin
      check("pulse_exclusive", {63'd0, cmd_ok & cmd_err}, 64'd0);
      if (cmd_ok)  ok_seen++;
      if (cmd_err) err_seen++;
      $display("pulse ok=%0d err=%0d duty=%h", cmd_ok, cmd_err, duty_flat);
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_pulse: got ok=%0d err=%0d expected no pulse", cmd_ok, cmd_err);
      end else begin
        e = sb.pop_front();
        check("pulse_kind_ok", {63'd0, cmd_ok}, {63'd0, e.is_ok});
        check("duty_at_pulse", {32'd0, duty_flat}, {32'd0, e.duty});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    data_ready = 1'b0;
    uart_data  = 8'h00;
    idle(3);
    check("reset_duty", {32'd0, duty_flat}, 64'd0);
    check("reset_ok",   {63'd0, cmd_ok},  64'd0);
    check("reset_err",  {63'd0, cmd_err}, 64'd0);
    check("reset_busy", {63'd0, busy},    64'd0);
    reset = 1'b0;
    idle(2);

    // "D250\n": channel 2 = 50, busy across the line
    expect_pulse(1'b1, 32'h0032_0000);
    send_byte("D");
    check("busy_after_D", {63'd0, busy}, 64'd1);
    send_str("250");
    check("busy_mid_line", {63'd0, busy}, 64'd1);
    send_byte(8'h0A);
    check("busy_after_lf", {63'd0, busy}, 64'd0);
    check("duty_d250", {32'd0, duty_flat}, 64'h0032_0000);
    idle(2);

    // "d0255\r": clamp to 100 on channel 0; "D17\n": channel 1 = 7
    expect_pulse(1'b1, 32'h0032_0064);
    send_str("d0255");
    send_byte(8'h0D);
    idle(2);
    expect_pulse(1'b1, 32'h0032_0764);
    send_str("D17\n");
    idle(2);
    check("no_err_yet", err_seen, 0);
    check("ok_count_3", ok_seen, 3);

    // Out-of-range channel
    expect_pulse(1'b0, 32'h0032_0764);
    send_str("D51\n");
    check("busy_after_d51", {63'd0, busy}, 64'd0);
    idle(2);

    // Too many digits: error on the 4th digit, rest discarded
    expect_pulse(1'b0, 32'h0032_0764);
    send_str("D3123");
    check("no_err_before_4th", {63'd0, cmd_err}, 64'd0);
    send_byte("4");
    check("err_on_4th", {63'd0, cmd_err}, 64'd1);
    check("busy_discard", {63'd0, busy}, 64'd1);
    send_str("\n");
    check("idle_after_discard", {63'd0, busy}, 64'd0);
    idle(2);

    // Bad lines with blank lines in between
    send_str("\n");
    expect_pulse(1'b0, 32'h0032_0764);
    send_str("X9\n");
    send_str("\n");
    expect_pulse(1'b0, 32'h0032_0764);
    send_str("D\n");
    expect_pulse(1'b0, 32'h0032_0764);
    send_str("D2\n");
    send_str("\n");
    idle(2);
    check("duty_after_bad", {32'd0, duty_flat}, 64'h0032_0764);

    // Timeout in VAL: 16 idle cycles abort the line
    expect_pulse(1'b0, 32'h0032_0764);
    send_str("D3");
    idle(15);
    check("busy_before_timeout", {63'd0, busy}, 64'd1);
    idle(1);
    check("busy_after_timeout", {63'd0, busy}, 64'd0);
    idle(2);

    // Byte on the firing cycle wins
    expect_pulse(1'b1, 32'h0532_0764);
    send_str("D3");
    idle(15);
    send_byte("5");
    check("busy_byte_wins", {63'd0, busy}, 64'd1);
    send_byte(8'h0A);
    check("duty_byte_wins", {32'd0, duty_flat}, 64'h0532_0764);
    idle(2);

    // Timeout out of DISCARD: no second pulse
    expect_pulse(1'b0, 32'h0532_0764);
    send_byte("X");
    idle(16);
    check("busy_discard_timeout", {63'd0, busy}, 64'd0);
    idle(3);

    // Reset mid-line discards the partial command
    send_str("D29");
    reset = 1'b1;
    @(negedge clk);
    check("midreset_duty", {32'd0, duty_flat}, 64'd0);
    check("midreset_busy", {63'd0, busy}, 64'd0);
    check("midreset_pulses", {62'd0, cmd_ok, cmd_err}, 64'd0);
    reset = 1'b0;
    idle(1);
    expect_pulse(1'b0, 32'h0000_0000);
    send_str("0\n");
    check("busy_after_0", {63'd0, busy}, 64'd0);
    idle(3);

    check("scoreboard_empty", sb.size(), 0);
    check("ok_total", ok_seen, 4);
    check("err_total", err_seen, 8);
    check("final_duty", {32'd0, duty_flat}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/duty_command_parser.md
Name: duty_command_parser

Overview:
- Multi-channel, multi-digit successor to the single-digit duty parser.
- Consumes received UART bytes and decodes line commands of the form "D<ch><decimal value><CR|LF>", e.g. "D250\n" sets channel 2 to 50.
- Keeps one registered duty value per channel and sits between the UART receiver and the PWM channel bank.
- Reports per-line success or error pulses, and uses an inter-byte timeout to recover from abandoned lines.

Parameters:
- NUM_CH, 4: number of duty channels, legal range 1..10; the channel is selected by one ASCII digit.
- DUTY_W, 8: width of each duty register.
- MAX_DUTY, 100: clamp ceiling for written values; must fit in DUTY_W.
- MAX_DIGITS, 3: maximum number of value digits per command, range 1..4.
- TIMEOUT_CYC, 1000000: idle clock cycles allowed mid-line before abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- uart_data  in  8  received byte, valid when data_ready=1
- data_ready  in  1  one byte is consumed on every cycle this is high
- duty_flat  out  NUM_CH*DUTY_W  channel k occupies bits [k*DUTY_W +: DUTY_W]
- cmd_ok  out  1  one-cycle pulse when a valid command is committed
- cmd_err  out  1  one-cycle pulse when a line is rejected or times out
- busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (asynchronous, active-high):
  - All duty registers = 0; cmd_ok = 0, cmd_err = 0; FSM = IDLE; accumulator, digit count and timer = 0.
  - Reset asserted mid-line discards the partial command; no pulse is issued.
- Terminator set T = {0x0D, 0x0A}. Digit = 0x30..0x39, with value d = byte - 0x30.
- FSM states: IDLE, CHAN, VAL, DISCARD. All transitions occur on a clk edge with data_ready=1, except the timeout.
  - IDLE:
    - 'D' or 'd' -> CHAN.
    - T -> stay in IDLE with no pulse (blank lines are ignored).
    - Any other byte -> DISCARD and pulse cmd_err.
  - CHAN:
    - Digit with d < NUM_CH -> latch ch = d, clear accumulator and digit count -> VAL.
    - Any other byte, including T and out-of-range digits -> pulse cmd_err. Next state is IDLE if the byte is in T, otherwise DISCARD.
  - VAL:
    - Digit with count < MAX_DIGITS -> acc = acc*10 + d, count++.
    - Digit with count == MAX_DIGITS -> DISCARD and pulse cmd_err.
    - T with count == 0 -> IDLE and pulse cmd_err.
    - T with count > 0 -> duty[ch] = min(acc, MAX_DUTY), truncated to DUTY_W; pulse cmd_ok; -> IDLE.
    - Any other byte -> DISCARD and pulse cmd_err.
  - DISCARD:
    - T -> IDLE with no additional pulse.
    - Any other byte -> stay in DISCARD.
- Each bad line produces exactly one cmd_err pulse.
- Accumulator width is 4*MAX_DIGITS bits, which never overflows. The clamp compare is done at full accumulator width.
- Latency:
  - The duty register and cmd_ok update on the same edge that samples the terminator, and are visible the next cycle.
  - Other channels are never disturbed by a write.
- cmd_ok and cmd_err are registered, high for exactly one cycle, and never asserted together.
- busy is a combinational decode of state != IDLE.
- Timeout:
  - The timer counts cycles with data_ready=0 while the FSM is not in IDLE, and clears on every consumed byte and on entry to IDLE.
  - When the timer reaches TIMEOUT_CYC -> IDLE. A pulse is issued only when leaving CHAN or VAL; leaving DISCARD produces no pulse.
  - If data_ready=1 on the same cycle the timeout would fire, the byte wins: it is processed normally and the timer clears.
  - With TIMEOUT_CYC = 0 the timer is inert.
- Back-to-back bytes on consecutive cycles must be accepted with no dead cycles.

Test Plan:
- Reset, then send "D250\n" -> channel 2 reads 50 on the cycle after the LF; one cmd_ok pulse; channels 0, 1 and 3 stay 0; busy is high from the 'D' until after the LF.
- Send "d0255\r" -> channel 0 reads 100 (clamped); send "D17\n" -> channel 1 reads 7; cmd_ok pulses twice; cmd_err never asserts.
- Send "D51\n" with NUM_CH=4 -> one cmd_err pulse, no register change. Send "D31234\n" -> one cmd_err on the 4th digit, the rest of the line is discarded, channel 3 is unchanged, and the FSM returns to IDLE on the LF.
- Send "X9\n", then "D\n", then "D2\n" -> cmd_err pulses once per line (3 total); all duty registers unchanged; blank "\n" lines produce no pulse.
- With TIMEOUT_CYC=16: send "D3" then idle 16 cycles -> cmd_err pulse, busy drops. Send a byte exactly on cycle 16 -> it is processed and no timeout pulse fires.
- Send "D29" and assert reset before the LF, then send "0\n" -> all duty registers 0, no pulses, "0" is rejected with one cmd_err.
